multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control unit: Moore FSM sequencing fetch, decode,
// memory, ALU, branch and jump steps, with memory wait states on Mem_Ready.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Op,
    input  logic       Zero,
    input  logic       Mem_Ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALU_Op,
    output logic       Illegal_Instr,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    // State-only control fields; the in_* flags qualify the input-dependent terms.
    typedef struct packed {
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_write;
        logic       in_fetch;
        logic       in_decode;
        logic       in_beq;
        logic       in_jal;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        adr_src:    1'b0,
        alu_src_a:  2'b00,
        alu_src_b:  2'b00,
        result_src: 2'b00,
        alu_op:     2'b00,
        reg_write:  1'b0,
        mem_write:  1'b0,
        in_fetch:   1'b0,
        in_decode:  1'b0,
        in_beq:     1'b0,
        in_jal:     1'b0
    };

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t state_r;
    state_t next_state_s;
    ctrl_t  ctrl_r;
    logic   op_legal_s;

    function automatic logic op_is_legal(input logic [6:0] op);
        logic legal;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE,
            OP_ITYPE, OP_BEQ, OP_JAL: legal = 1'b1;
            default:                  legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Unreachable codes fall to the default and decode to all-zero controls.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            S_FETCH: begin
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.in_fetch   = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
                c.in_decode = 1'b1;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b11;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.in_beq    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.in_jal    = 1'b1;
            end
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    assign op_legal_s = op_is_legal(Op);

    // Next-state selection; every wait state holds until Mem_Ready.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH:    next_state_s = Mem_Ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
                    OP_RTYPE:          next_state_s = S_EXECUTER;
                    OP_ITYPE:          next_state_s = S_EXECUTEI;
                    OP_BEQ:            next_state_s = S_BEQ;
                    OP_JAL:            next_state_s = S_JAL;
                    default:           next_state_s = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state_s = Op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  next_state_s = Mem_Ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    next_state_s = S_FETCH;
            S_MEMWRITE: next_state_s = Mem_Ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: next_state_s = S_ALUWB;
            S_EXECUTEI: next_state_s = S_ALUWB;
            S_ALUWB:    next_state_s = S_FETCH;
            S_BEQ:      next_state_s = S_FETCH;
            S_JAL:      next_state_s = S_ALUWB;
            default:    next_state_s = S_FETCH;
        endcase
    end

    // State register; control fields are registered from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
            ctrl_r  <= ctrl_for(S_FETCH);
        end else begin
            state_r <= next_state_s;
            ctrl_r  <= ctrl_for(next_state_s);
        end
    end

    // While reset is high the outputs show FETCH with every enable held off.
    assign PCWrite       = ~reset & ((ctrl_r.in_fetch & Mem_Ready) |
                                     (ctrl_r.in_beq & Zero) | ctrl_r.in_jal);
    assign IRWrite       = ~reset & ctrl_r.in_fetch & Mem_Ready;
    assign MemWrite      = ~reset & ctrl_r.mem_write;
    assign RegWrite      = ~reset & ctrl_r.reg_write;
    assign Illegal_Instr = ~reset & ctrl_r.in_decode & ~op_legal_s;
    assign AdrSrc        = reset ? 1'b0  : ctrl_r.adr_src;
    assign ALUSrcA       = reset ? 2'b00 : ctrl_r.alu_src_a;
    assign ALUSrcB       = reset ? 2'b10 : ctrl_r.alu_src_b;
    assign ResultSrc     = reset ? 2'b10 : ctrl_r.result_src;
    assign ALU_Op        = reset ? 2'b00 : ctrl_r.alu_op;
    assign State         = reset ? 4'd0  : state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control plus latency sequences.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [6:0] Op;
    logic       Zero;
    logic       Mem_Ready;
    logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, Illegal_Instr;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALU_Op;
    logic [3:0] State;

    int total;
    int bad;

    multicycle_control dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .Mem_Ready(Mem_Ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALU_Op(ALU_Op),
        .Illegal_Instr(Illegal_Instr), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [6:0]  op;
        logic        zero;
        logic        rdy;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;
    localparam logic [6:0] NUL = 7'b0000000;

    // {State, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, Illegal, A, B, Result, ALU_Op}
    function automatic logic [17:0] pk(input logic [3:0] st, input logic pcw, input logic irw,
                                       input logic mw, input logic rw, input logic adr,
                                       input logic ill, input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] res, input logic [1:0] aop);
        return {st, pcw, irw, mw, rw, adr, ill, a, b, res, aop};
    endfunction

    function automatic logic [17:0] e_fetch(input logic rdy);
        return pk(4'd0, rdy, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00);
    endfunction
    function automatic logic [17:0] e_dec(input logic ill);
        return pk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ill, 2'b01, 2'b01, 2'b00, 2'b00);
    endfunction
    function automatic logic [17:0] e_madr();
        return pk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00);
    endfunction
    function automatic logic [17:0] e_mrd();
        return pk(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    endfunction
    function automatic logic [17:0] e_mwb();
        return pk(4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00);
    endfunction
    function automatic logic [17:0] e_mwr();
        return pk(4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    endfunction
    function automatic logic [17:0] e_exr();
        return pk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10);
    endfunction
    function automatic logic [17:0] e_exi();
        return pk(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b11);
    endfunction
    function automatic logic [17:0] e_aluwb();
        return pk(4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    endfunction
    function automatic logic [17:0] e_beq(input logic z);
        return pk(4'd9, z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01);
    endfunction
    function automatic logic [17:0] e_jal();
        return pk(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00);
    endfunction

    function automatic void add(input logic rst, input logic [6:0] op, input logic zero,
                                input logic rdy, input logic [17:0] exp);
        vecs.push_back('{rst: rst, op: op, zero: zero, rdy: rdy, exp: exp});
    endfunction

    logic [17:0] act;
    assign act = {State, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, Illegal_Instr,
                  ALUSrcA, ALUSrcB, ResultSrc, ALU_Op};

    task automatic measure(input logic [6:0] op, input int expected, input string name);
        int cycles;
        @(negedge clk);
        reset = 1'b1; Mem_Ready = 1'b1; Op = op; Zero = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            #1;
        end while (State != 4'd0 && cycles < 20);
        total++;
        if (cycles != expected) begin
            bad++;
            $display("FAIL latency_%s: got %0d cycles, want %0d", name, cycles, expected);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; Op = NUL; Zero = 1'b0; Mem_Ready = 1'b0;

        // lw, then a wait cycle in FETCH
        add(1'b1, LW, 1'b0, 1'b1, e_fetch(1'b0));
        add(1'b0, LW, 1'b0, 1'b1, e_fetch(1'b1));
        add(1'b0, LW, 1'b0, 1'b1, e_dec(1'b0));
        add(1'b0, LW, 1'b0, 1'b1, e_madr());
        add(1'b0, LW, 1'b0, 1'b1, e_mrd());
        add(1'b0, LW, 1'b0, 1'b1, e_mwb());
        add(1'b0, LW, 1'b0, 1'b0, e_fetch(1'b0));
        // sw with three wait cycles in MEMWRITE
        add(1'b0, SW, 1'b0, 1'b1, e_fetch(1'b1));
        add(1'b0, SW, 1'b0, 1'b1, e_dec(1'b0));
        add(1'b0, SW, 1'b0, 1'b1, e_madr());
        add(1'b0, SW, 1'b0, 1'b0, e_mwr());
        add(1'b0, SW, 1'b0, 1'b0, e_mwr());
        add(1'b0, SW, 1'b0, 1'b0, e_mwr());
        add(1'b0, SW, 1'b0, 1'b1, e_mwr());
        // beq taken, then not taken
        add(1'b0, BQ, 1'b1, 1'b1, e_fetch(1'b1));
        add(1'b0, BQ, 1'b1, 1'b1, e_dec(1'b0));
        add(1'b0, BQ, 1'b1, 1'b1, e_beq(1'b1));
        add(1'b0, BQ, 1'b0, 1'b1, e_fetch(1'b1));
        add(1'b0, BQ, 1'b0, 1'b1, e_dec(1'b0));
        add(1'b0, BQ, 1'b0, 1'b1, e_beq(1'b0));
        // R-type (Zero high must not leak into PCWrite), then I-type
        add(1'b0, RT, 1'b1, 1'b1, e_fetch(1'b1));
        add(1'b0, RT, 1'b1, 1'b1, e_dec(1'b0));
        add(1'b0, RT, 1'b1, 1'b1, e_exr());
        add(1'b0, RT, 1'b1, 1'b1, e_aluwb());
        add(1'b0, IT, 1'b0, 1'b1, e_fetch(1'b1));
        add(1'b0, IT, 1'b0, 1'b1, e_dec(1'b0));
        add(1'b0, IT, 1'b0, 1'b1, e_exi());
        add(1'b0, IT, 1'b0, 1'b1, e_aluwb());
        // jal
        add(1'b0, JL, 1'b0, 1'b1, e_fetch(1'b1));
        add(1'b0, JL, 1'b0, 1'b1, e_dec(1'b0));
        add(1'b0, JL, 1'b0, 1'b1, e_jal());
        add(1'b0, JL, 1'b0, 1'b1, e_aluwb());
        // illegal opcode returns straight to FETCH
        add(1'b0, BAD, 1'b0, 1'b1, e_fetch(1'b1));
        add(1'b0, BAD, 1'b0, 1'b1, e_dec(1'b1));
        add(1'b0, BAD, 1'b0, 1'b0, e_fetch(1'b0));
        // reset in the middle of a MEMWRITE wait
        add(1'b0, SW, 1'b0, 1'b1, e_fetch(1'b1));
        add(1'b0, SW, 1'b0, 1'b1, e_dec(1'b0));
        add(1'b0, SW, 1'b0, 1'b1, e_madr());
        add(1'b0, SW, 1'b0, 1'b0, e_mwr());
        add(1'b1, SW, 1'b0, 1'b0, e_fetch(1'b0));
        add(1'b0, SW, 1'b0, 1'b0, e_fetch(1'b0));
        // all-zero opcode is illegal too; then lw with a MEMREAD wait
        add(1'b0, NUL, 1'b0, 1'b1, e_fetch(1'b1));
        add(1'b0, NUL, 1'b0, 1'b1, e_dec(1'b1));
        add(1'b0, LW, 1'b0, 1'b1, e_fetch(1'b1));
        add(1'b0, LW, 1'b0, 1'b1, e_dec(1'b0));
        add(1'b0, LW, 1'b0, 1'b1, e_madr());
        add(1'b0, LW, 1'b0, 1'b0, e_mrd());
        add(1'b0, LW, 1'b0, 1'b1, e_mrd());
        add(1'b0, LW, 1'b0, 1'b0, e_mwb());
        add(1'b0, LW, 1'b0, 1'b0, e_fetch(1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; Op = vecs[i].op; Zero = vecs[i].zero; Mem_Ready = vecs[i].rdy;
            #1;
            total++;
            if (act !== vecs[i].exp) begin
                bad++;
                $display("FAIL vec%0d: got %05h, want %05h", i, act, vecs[i].exp);
            end
        end

        measure(LW,  5, "lw");
        measure(SW,  4, "sw");
        measure(RT,  4, "rtype");
        measure(IT,  4, "itype");
        measure(JL,  4, "jal");
        measure(BQ,  3, "beq");
        measure(BAD, 2, "illegal");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
